order_book_topn: RTL and testbench

- Parametrised successor to the fixed 4-level bid-side book.
- Keeps the best DEPTH resting orders of one configurable side, sorted by price with time priority. Handles add, partial cancel/execute and delete messages instead of add-only.
- Sits after the message parser. Takes decoded fields over a valid/ready handshake and drives the flattened top-of-book outputs to the strategy logic.

---
 rtl/order_book_topn.sv | 243 ++++++++++++++++++++++++
 tb/tb_order_book_topn.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_book_topn.sv
// Top-N book for one side: keeps the best DEPTH orders sorted by price with time priority.
// Optional saturating drop/evict/miss counters are enabled by defining ORDER_BOOK_STATS_EN.
module order_book_topn #(
  parameter int DEPTH    = 4,
  parameter int ID_W     = 32,
  parameter int QTY_W    = 32,
  parameter int PRICE_W  = 64,
  parameter int SIDE_BID = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  // valid/ready: a message transfers on a rising edge where msg_valid and msg_ready are both high;
  // msg_ready is high only while idle, and the fields are captured on that edge.
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [7:0]                 msg_type,
  input  logic                       msg_side,
  input  logic [ID_W-1:0]            msg_order_id,
  input  logic [QTY_W-1:0]           msg_qty,
  input  logic [PRICE_W-1:0]         msg_price,
  output logic [DEPTH*ID_W-1:0]      top_order_id,
  output logic [DEPTH*QTY_W-1:0]     top_qty,
  output logic [DEPTH*PRICE_W-1:0]   top_price,
  output logic [DEPTH-1:0]           top_valid,
  output logic [CW-1:0]              level_count,
  output logic                       upd_done,
  output logic                       id_miss,
`ifdef ORDER_BOOK_STATS_EN
  output logic [15:0]                drop_cnt,
  output logic [15:0]                evict_cnt,
  output logic [15:0]                miss_cnt,
`endif
  output logic [1:0]                 dbg_state
);

  localparam logic [7:0] T_ADD = 8'h41;
  localparam logic [7:0] T_CXL = 8'h58;
  localparam logic [7:0] T_EXE = 8'h45;
  localparam logic [7:0] T_DEL = 8'h44;
  localparam logic       SIDE_SEL = (SIDE_BID != 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEARCH = 2'd1, S_UPDATE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [7:0]         m_type_q;
  logic               m_side_q;
  logic [ID_W-1:0]    m_id_q;
  logic [QTY_W-1:0]   m_qty_q;
  logic [PRICE_W-1:0] m_price_q;

  logic [ID_W-1:0]    id_q    [DEPTH];
  logic [ID_W-1:0]    id_d    [DEPTH];
  logic [QTY_W-1:0]   qty_q   [DEPTH];
  logic [QTY_W-1:0]   qty_d   [DEPTH];
  logic [PRICE_W-1:0] price_q [DEPTH];
  logic [PRICE_W-1:0] price_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;

  logic [CW-1:0]      idx_q;
  logic               found_q;
  logic               upd_done_q, id_miss_q;

  logic [CW-1:0]      cnt, ins_idx, match_idx;
  logic               match_hit;
  logic [QTY_W-1:0]   tgt_qty;
  logic               filt, is_add, is_xe, is_del;
  logic               drop, ins, evict, miss, rem, red;

  function automatic logic is_better(input logic [PRICE_W-1:0] a, input logic [PRICE_W-1:0] b);
    return SIDE_SEL ? (a > b) : (a < b);
  endfunction

  // Parallel compare of the latched message against every occupied level; lowest index wins.
  always_comb begin
    cnt       = '0;
    ins_idx   = '0;
    match_idx = '0;
    match_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) cnt = cnt + CW'(valid_q[k]);
    ins_idx = cnt;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && is_better(m_price_q, price_q[k])) ins_idx = CW'(k);
      if (valid_q[k] && (id_q[k] == m_id_q)) begin
        match_idx = CW'(k);
        match_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    msg_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_d = S_SEARCH;
      end
      S_SEARCH: state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tgt_qty = '0;
    for (int k = 0; k < DEPTH; k++)
      if (idx_q == CW'(k)) tgt_qty = qty_q[k];
    filt   = (m_side_q != SIDE_SEL) ||
             !((m_type_q == T_ADD) || (m_type_q == T_CXL) ||
               (m_type_q == T_EXE) || (m_type_q == T_DEL));
    is_add = !filt && (m_type_q == T_ADD);
    is_xe  = !filt && ((m_type_q == T_CXL) || (m_type_q == T_EXE));
    is_del = !filt && (m_type_q == T_DEL);
    drop   = is_add && ((m_qty_q == '0) || (idx_q == CW'(DEPTH)));
    ins    = is_add && !drop;
    evict  = ins && valid_q[DEPTH-1];
    miss   = (is_xe || is_del) && !found_q;
    rem    = found_q && (is_del || (is_xe && (m_qty_q >= tgt_qty)));
    red    = found_q && is_xe && (m_qty_q < tgt_qty);
  end

  // Insert shifts levels at and below idx down by one; remove shifts them up and zero-fills the tail.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      id_d[k]    = id_q[k];
      qty_d[k]   = qty_q[k];
      price_d[k] = price_q[k];
      if (ins) begin
        if (CW'(k) == idx_q) begin
          id_d[k]    = m_id_q;
          qty_d[k]   = m_qty_q;
          price_d[k] = m_price_q;
          valid_d[k] = 1'b1;
        end else if (CW'(k) > idx_q) begin
          id_d[k]    = id_q[(k > 0) ? k - 1 : 0];
          qty_d[k]   = qty_q[(k > 0) ? k - 1 : 0];
          price_d[k] = price_q[(k > 0) ? k - 1 : 0];
          valid_d[k] = valid_q[(k > 0) ? k - 1 : 0];
        end
      end else if (rem) begin
        if (CW'(k) >= idx_q) begin
          if (k == DEPTH - 1) begin
            id_d[k]    = '0;
            qty_d[k]   = '0;
            price_d[k] = '0;
            valid_d[k] = 1'b0;
          end else begin
            id_d[k]    = id_q[(k < DEPTH - 1) ? k + 1 : k];
            qty_d[k]   = qty_q[(k < DEPTH - 1) ? k + 1 : k];
            price_d[k] = price_q[(k < DEPTH - 1) ? k + 1 : k];
            valid_d[k] = valid_q[(k < DEPTH - 1) ? k + 1 : k];
          end
        end
      end else if (red && (CW'(k) == idx_q)) begin
        qty_d[k] = qty_q[k] - m_qty_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      m_type_q   <= '0;
      m_side_q   <= 1'b0;
      m_id_q     <= '0;
      m_qty_q    <= '0;
      m_price_q  <= '0;
      idx_q      <= '0;
      found_q    <= 1'b0;
      upd_done_q <= 1'b0;
      id_miss_q  <= 1'b0;
      valid_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        id_q[k]    <= '0;
        qty_q[k]   <= '0;
        price_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      upd_done_q <= (state_q == S_UPDATE);
      id_miss_q  <= (state_q == S_UPDATE) && miss;
      if ((state_q == S_IDLE) && msg_valid) begin
        m_type_q  <= msg_type;
        m_side_q  <= msg_side;
        m_id_q    <= msg_order_id;
        m_qty_q   <= msg_qty;
        m_price_q <= msg_price;
      end
      if (state_q == S_SEARCH) begin
        idx_q   <= (m_type_q == T_ADD) ? ins_idx : match_idx;
        found_q <= match_hit;
      end
      if (state_q == S_UPDATE) begin
        valid_q <= valid_d;
        for (int k = 0; k < DEPTH; k++) begin
          id_q[k]    <= id_d[k];
          qty_q[k]   <= qty_d[k];
          price_q[k] <= price_d[k];
        end
      end
    end
  end

`ifdef ORDER_BOOK_STATS_EN
  logic [15:0] drop_cnt_q, evict_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q  <= '0;
      evict_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else if (state_q == S_UPDATE) begin
      if (drop  && (drop_cnt_q  != 16'hFFFF)) drop_cnt_q  <= drop_cnt_q + 16'd1;
      if (evict && (evict_cnt_q != 16'hFFFF)) evict_cnt_q <= evict_cnt_q + 16'd1;
      if (miss  && (miss_cnt_q  != 16'hFFFF)) miss_cnt_q  <= miss_cnt_q + 16'd1;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign evict_cnt = evict_cnt_q;
  assign miss_cnt  = miss_cnt_q;
`endif

  always_comb begin
    top_order_id = '0;
    top_qty      = '0;
    top_price    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      top_order_id[k*ID_W +: ID_W]     = id_q[k];
      top_qty[k*QTY_W +: QTY_W]        = qty_q[k];
      top_price[k*PRICE_W +: PRICE_W]  = price_q[k];
    end
  end

  assign top_valid   = valid_q;
  assign level_count = cnt;
  assign upd_done    = upd_done_q;
  assign id_miss     = id_miss_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_order_book_topn.sv
// Bench for order_book_topn: a bid book checked against a queue-based reference book,
// plus a small ask-side instance checked with directed values.
module tb_order_book_topn;
  localparam int DEPTH   = 4;
  localparam int ID_W    = 32;
  localparam int QTY_W   = 32;
  localparam int PRICE_W = 64;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int IDF     = DEPTH * ID_W;
  localparam int QF      = DEPTH * QTY_W;
  localparam int PF      = DEPTH * PRICE_W;
  localparam int EW      = IDF + QF + PF + DEPTH + CW + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                     msg_valid, msg_ready, msg_side;
  logic [7:0]               msg_type;
  logic [ID_W-1:0]          msg_order_id;
  logic [QTY_W-1:0]         msg_qty;
  logic [PRICE_W-1:0]       msg_price;
  logic [IDF-1:0]           top_order_id;
  logic [QF-1:0]            top_qty;
  logic [PF-1:0]            top_price;
  logic [DEPTH-1:0]         top_valid;
  logic [CW-1:0]            level_count;
  logic                     upd_done, id_miss;
  logic [1:0]               dbg_state;

  logic                     a_valid, a_ready, a_side;
  logic [7:0]               a_type;
  logic [ID_W-1:0]          a_id;
  logic [QTY_W-1:0]         a_qty;
  logic [PRICE_W-1:0]       a_price;
  logic [IDF-1:0]           a_top_id;
  logic [QF-1:0]            a_top_qty;
  logic [PF-1:0]            a_top_price;
  logic [DEPTH-1:0]         a_top_valid;
  logic [CW-1:0]            a_level_count;
  logic                     a_upd_done, a_id_miss;
  logic [1:0]               a_dbg_state;
`ifdef ORDER_BOOK_STATS_EN
  logic [15:0] drop_cnt, evict_cnt, miss_cnt;
  logic [15:0] a_drop_cnt, a_evict_cnt, a_miss_cnt;
`endif

  order_book_topn #(.DEPTH(DEPTH), .ID_W(ID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W), .SIDE_BID(1)) u_bid (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_type(msg_type), .msg_side(msg_side), .msg_order_id(msg_order_id),
    .msg_qty(msg_qty), .msg_price(msg_price), .top_order_id(top_order_id),
    .top_qty(top_qty), .top_price(top_price), .top_valid(top_valid),
    .level_count(level_count), .upd_done(upd_done), .id_miss(id_miss),
`ifdef ORDER_BOOK_STATS_EN
    .drop_cnt(drop_cnt), .evict_cnt(evict_cnt), .miss_cnt(miss_cnt),
`endif
    .dbg_state(dbg_state)
  );

  order_book_topn #(.DEPTH(DEPTH), .ID_W(ID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W), .SIDE_BID(0)) u_ask (
    .clk(clk), .reset(reset), .msg_valid(a_valid), .msg_ready(a_ready),
    .msg_type(a_type), .msg_side(a_side), .msg_order_id(a_id),
    .msg_qty(a_qty), .msg_price(a_price), .top_order_id(a_top_id),
    .top_qty(a_top_qty), .top_price(a_top_price), .top_valid(a_top_valid),
    .level_count(a_level_count), .upd_done(a_upd_done), .id_miss(a_id_miss),
`ifdef ORDER_BOOK_STATS_EN
    .drop_cnt(a_drop_cnt), .evict_cnt(a_evict_cnt), .miss_cnt(a_miss_cnt),
`endif
    .dbg_state(a_dbg_state)
  );

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [QTY_W-1:0]   qty;
    logic [PRICE_W-1:0] price;
  } ord_t;

  ord_t           book_m[$];
  logic [EW-1:0]  exp_q[$];
  int             m_drop, m_evict, m_miss;
  int             n_assert = 0;
  int             n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference bid book: sorted queue, ties go behind existing orders, tail trimmed to DEPTH.
  task automatic model_apply(input logic [7:0] t, input logic s, input logic [ID_W-1:0] id,
                             input logic [QTY_W-1:0] q, input logic [PRICE_W-1:0] p,
                             output logic miss);
    int   pos;
    int   hit;
    ord_t o;
    miss = 1'b0;
    if (s !== 1'b1) return;
    case (t)
      8'h41: begin
        if (q == '0) begin m_drop++; return; end
        pos = book_m.size();
        for (int i = 0; i < book_m.size(); i++)
          if (p > book_m[i].price) begin pos = i; break; end
        if (pos >= DEPTH) begin m_drop++; return; end
        o.id = id; o.qty = q; o.price = p;
        book_m.insert(pos, o);
        if (book_m.size() > DEPTH) begin
          void'(book_m.pop_back());
          m_evict++;
        end
      end
      8'h58, 8'h45, 8'h44: begin
        hit = -1;
        for (int i = 0; i < book_m.size(); i++)
          if (book_m[i].id == id) begin hit = i; break; end
        if (hit < 0) begin miss = 1'b1; m_miss++; end
        else if (t != 8'h44 && q < book_m[hit].qty) book_m[hit].qty = book_m[hit].qty - q;
        else book_m.delete(hit);
      end
      default: ;
    endcase
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic miss);
    logic [IDF-1:0]   ids;
    logic [QF-1:0]    qtys;
    logic [PF-1:0]    prices;
    logic [DEPTH-1:0] vld;
    ids = '0; qtys = '0; prices = '0; vld = '0;
    for (int k = 0; k < book_m.size(); k++) begin
      ids[k*ID_W +: ID_W]       = book_m[k].id;
      qtys[k*QTY_W +: QTY_W]    = book_m[k].qty;
      prices[k*PRICE_W +: PRICE_W] = book_m[k].price;
      vld[k]                    = 1'b1;
    end
    return {miss, CW'(book_m.size()), vld, prices, qtys, ids};
  endfunction

  task automatic send(input logic [7:0] t, input logic s, input logic [ID_W-1:0] id,
                      input logic [QTY_W-1:0] q, input logic [PRICE_W-1:0] p);
    logic          miss;
    logic [EW-1:0] e;
    int            cyc;
    bit            seen;
    @(negedge clk);
    for (int i = 0; i < 20 && !msg_ready; i++) @(negedge clk);
    check("ready_before_send", msg_ready, 1'b1);
    msg_valid = 1'b1; msg_type = t; msg_side = s; msg_order_id = id; msg_qty = q; msg_price = p;
    model_apply(t, s, id, q, p, miss);
    exp_q.push_back(pack_exp(miss));
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_type = 8'($urandom); msg_side = 1'($urandom); msg_order_id = $urandom;
    msg_qty = $urandom; msg_price = {$urandom, $urandom};
    @(negedge clk);
    check("busy_ready_low", msg_ready, 1'b0);
    cyc = 1; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (upd_done) begin seen = 1'b1; break; end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("upd_done_seen", seen, 1'b1);
    e = exp_q.pop_front();
    if (seen) begin
      check("upd_latency", cyc, 3);
      check("top_order_id", top_order_id, e[0 +: IDF]);
      check("top_qty", top_qty, e[IDF +: QF]);
      check("top_price", top_price, e[IDF+QF +: PF]);
      check("top_valid", top_valid, e[IDF+QF+PF +: DEPTH]);
      check("level_count", level_count, e[IDF+QF+PF+DEPTH +: CW]);
      check("id_miss", id_miss, e[EW-1]);
      check("ready_after", msg_ready, 1'b1);
`ifdef ORDER_BOOK_STATS_EN
      check("drop_cnt", drop_cnt, m_drop);
      check("evict_cnt", evict_cnt, m_evict);
      check("miss_cnt", miss_cnt, m_miss);
`endif
    end
  endtask

  task automatic send_ask(input logic [ID_W-1:0] id, input logic [PRICE_W-1:0] p);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_type = 8'h41; a_side = 1'b0; a_id = id; a_qty = 32'd1; a_price = p;
    @(posedge clk);
    #1 a_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_upd_done) begin seen = 1'b1; break; end
    end
    check("ask_upd_done", seen, 1'b1);
  endtask

  initial begin
    logic          r_miss;
    logic [7:0]    r_t;
    logic [ID_W-1:0] r_id;
    int            op;
    reset = 1'b1;
    msg_valid = 1'b0; msg_type = '0; msg_side = 1'b0; msg_order_id = '0; msg_qty = '0; msg_price = '0;
    a_valid = 1'b0; a_type = '0; a_side = 1'b0; a_id = '0; a_qty = '0; a_price = '0;
    m_drop = 0; m_evict = 0; m_miss = 0;
    repeat (2) @(negedge clk);
    check("rst_top_valid", top_valid, '0);
    check("rst_top_price", top_price, '0);
    check("rst_level_count", level_count, '0);
    check("rst_upd_done", upd_done, 1'b0);
    check("rst_id_miss", id_miss, 1'b0);
    check("rst_msg_ready", msg_ready, 1'b1);
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b0;

    send(8'h41, 1'b1, 32'd1, 32'd5, 64'd100);
    send(8'h41, 1'b1, 32'd2, 32'd6, 64'd120);
    send(8'h41, 1'b1, 32'd3, 32'd7, 64'd110);
    check("plan_prices3", top_price, {64'd0, 64'd100, 64'd110, 64'd120});
    check("plan_valid3", top_valid, 4'b0111);
    check("plan_count3", level_count, 3'd3);

    send(8'h41, 1'b1, 32'd4, 32'd8, 64'd105);
    send(8'h41, 1'b1, 32'd9, 32'd1, 64'd90);
    check("plan_drop_prices", top_price, {64'd100, 64'd105, 64'd110, 64'd120});
    send(8'h41, 1'b1, 32'd10, 32'd3, 64'd130);
    check("plan_evict_ids", top_order_id, {32'd4, 32'd3, 32'd2, 32'd10});

    send(8'h41, 1'b1, 32'd5, 32'd4, 64'd110);
    check("plan_time_prio", top_order_id, {32'd5, 32'd3, 32'd2, 32'd10});

    send(8'h45, 1'b1, 32'd2, 32'd2, 64'd0);
    check("plan_exec_qty", top_qty, {32'd4, 32'd7, 32'd4, 32'd3});
    send(8'h58, 1'b1, 32'd2, 32'd10, 64'd0);
    check("plan_cxl_ids", top_order_id, {32'd0, 32'd5, 32'd3, 32'd10});
    check("plan_cxl_valid", top_valid, 4'b0111);

    send(8'h44, 1'b1, 32'd77, 32'd0, 64'd0);
    send(8'h41, 1'b0, 32'd40, 32'd5, 64'd200);
    send(8'h5A, 1'b1, 32'd10, 32'd5, 64'd0);
    send(8'h41, 1'b1, 32'd41, 32'd0, 64'd300);
    send(8'h58, 1'b1, 32'd5, 32'd4, 64'd0);
    send(8'h44, 1'b1, 32'd3, 32'd1, 64'd0);

    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        send(8'h41, 1'b1, 32'(200 + i), 32'($urandom_range(0, 9)), 64'($urandom_range(90, 140)));
      end else begin
        r_t = (op == 2) ? (($urandom_range(0, 1) == 0) ? 8'h58 : 8'h45) : 8'h44;
        r_id = 32'd999;
        if (book_m.size() > 0 && $urandom_range(0, 3) != 0)
          r_id = book_m[$urandom_range(0, book_m.size() - 1)].id;
        send(r_t, 1'b1, r_id, 32'($urandom_range(1, 12)), 64'($urandom));
      end
    end

    // Reset while an add is in its search cycle: message lost, book empty at once.
    @(negedge clk);
    msg_valid = 1'b1; msg_type = 8'h41; msg_side = 1'b1; msg_order_id = 32'd50;
    msg_qty = 32'd5; msg_price = 64'd500;
    @(posedge clk);
    #1 msg_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", msg_ready, 1'b1);
    check("mid_rst_valid", top_valid, '0);
    check("mid_rst_count", level_count, '0);
    check("mid_rst_ids", top_order_id, '0);
    book_m.delete();
    m_drop = 0; m_evict = 0; m_miss = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", upd_done, 1'b0);
    end
    check("mid_rst_book_empty", top_valid, '0);
    send(8'h41, 1'b1, 32'd60, 32'd2, 64'd50);

    send_ask(32'd1, 64'd100);
    send_ask(32'd2, 64'd90);
    check("ask_prices", a_top_price, {64'd0, 64'd0, 64'd100, 64'd90});
    check("ask_ids", a_top_id, {32'd0, 32'd0, 32'd1, 32'd2});
    check("ask_count", a_level_count, 3'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
